press_classifier: RTL and testbench

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_pkg.sv | 21 ++
 rtl/ms_tick_gen.sv | 31 +++
 rtl/press_classifier.sv | 134 +++++++++++++
 tb/tb_press_classifier.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared types and constants for the press classifier: FSM state encoding,
// the ms-per-second constant and a small max helper for counter sizing.
package press_pkg;

    localparam int MS_PER_SEC = 1000;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        LONG
    } state_t;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond tick: one-cycle strobe every CLK_FREQ/1000 cycles,
// asserted in the very first cycle after reset release.
module ms_tick_gen
    import press_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int DIV = CLK_FREQ / MS_PER_SEC;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] r_div;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (r_div == DW'(DIV - 1)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Tick while the divider sits at zero, so the strobe lands on cycle 0.
    assign tick = (r_div == '0);

endmodule

// File: rtl/press_classifier.sv
// Classifies a debounced button into short/long/double presses with optional
// auto-repeat while long-held (enabled by defining PRESS_REPEAT_EN).
module press_classifier
    import press_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int LONG_MS   = 800,
    parameter int DOUBLE_MS = 250,
    parameter int REPEAT_MS = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic db,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_press
);

    localparam int CNT_MAX = maxOf3(LONG_MS, DOUBLE_MS, REPEAT_MS);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_short;
    logic          r_long;
    logic          r_double;
    logic          w_tick;
    logic          w_longTimeout;
    logic          w_doubleTimeout;

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    assign w_longTimeout   = w_tick && (r_cnt == CW'(LONG_MS - 1));
    assign w_doubleTimeout = w_tick && (r_cnt == CW'(DOUBLE_MS - 1));

`ifdef PRESS_REPEAT_EN
    logic r_repeat;
    logic w_repeatTimeout;
    assign w_repeatTimeout = w_tick && (r_cnt == CW'(REPEAT_MS - 1));
`endif

    // Later assignments to r_cnt override the saturating increment whenever
    // the state changes; db events are tested before timeouts to give them priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
`ifdef PRESS_REPEAT_EN
            r_repeat <= 1'b0;
`endif
        end else begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
`ifdef PRESS_REPEAT_EN
            r_repeat <= 1'b0;
`endif
            if (w_tick && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (db) begin
                        r_state <= PRESS1;
                        r_cnt   <= '0;
                    end
                end
                PRESS1: begin
                    if (!db) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                    end else if (w_longTimeout) begin
                        r_state <= LONG;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end
                end
                GAP: begin
                    if (db) begin
                        r_state  <= PRESS2;
                        r_cnt    <= '0;
                        r_double <= 1'b1;
                    end else if (w_doubleTimeout) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_short <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (!db) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end
                LONG: begin
                    if (!db) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
`ifdef PRESS_REPEAT_EN
                    else if (w_repeatTimeout) begin
                        r_cnt    <= '0;
                        r_repeat <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_press = r_double;
`ifdef PRESS_REPEAT_EN
    assign repeat_press = r_repeat;
`else
    assign repeat_press = 1'b0;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier at 100 kHz (tick every 100 cycles),
// LONG_MS=10, DOUBLE_MS=4, REPEAT_MS=3; honours PRESS_REPEAT_EN if defined.
module tb_press_classifier;

    logic clk = 1'b0;
    logic reset_n;
    logic db;
    logic short_press;
    logic long_press;
    logic double_press;
    logic repeat_press;

    int edgeCnt;
    int errors = 0;
    int checks = 0;
    int shortCnt, longCnt, doubleCnt, repeatCnt, multiCnt;
    int shortStamp, longStamp, doubleStamp, repeatStamp;

    press_classifier #(
        .CLK_FREQ  (100_000),
        .LONG_MS   (10),
        .DOUBLE_MS (4),
        .REPEAT_MS (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .db           (db),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .repeat_press (repeat_press)
    );

    always #5 clk = ~clk;

    // Edge k after reset release leaves edgeCnt == k+1 at the following negedge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edgeCnt <= 0;
        else          edgeCnt <= edgeCnt + 1;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            shortCnt <= 0; longCnt <= 0; doubleCnt <= 0; repeatCnt <= 0; multiCnt <= 0;
            shortStamp <= -1; longStamp <= -1; doubleStamp <= -1; repeatStamp <= -1;
        end else begin
            if (short_press)  begin shortCnt  <= shortCnt + 1;  shortStamp  <= edgeCnt - 1; end
            if (long_press)   begin longCnt   <= longCnt + 1;   longStamp   <= edgeCnt - 1; end
            if (double_press) begin doubleCnt <= doubleCnt + 1; doubleStamp <= edgeCnt - 1; end
            if (repeat_press) begin repeatCnt <= repeatCnt + 1; repeatStamp <= edgeCnt - 1; end
            if ($countones({short_press, long_press, double_press, repeat_press}) > 1)
                multiCnt <= multiCnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitUntil(input int target);
        int guard;
        guard = 0;
        while (edgeCnt < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (edgeCnt < target) begin
            errors++;
            $display("[TB] FAIL timeout waiting for edge observed=%0d expected=%0d", edgeCnt, target);
        end
    endtask

    task automatic applyStimulus(input logic dbVal, input int atEdge);
        waitUntil(atEdge);
        db = dbVal;
    endtask

    task automatic applyReset(input logic dbAtRelease);
        @(negedge clk);
        reset_n = 1'b0;
        db = 1'b0;
        repeat (3) @(negedge clk);
        db = dbAtRelease;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        db = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset short", short_press, 1'b0);
        checkOutput("reset long", long_press, 1'b0);
        checkOutput("reset double", double_press, 1'b0);
        checkOutput("reset repeat", repeat_press, 1'b0);

        // Single short press: 300 cycles held, short at GAP timeout (edge 700).
        applyReset(1'b0);
        applyStimulus(1'b1, 50);
        applyStimulus(1'b0, 350);
        waitUntil(700);
        checkOutput("short before edge", short_press, 1'b0);
        waitUntil(701);
        checkOutput("short pulse high", short_press, 1'b1);
        waitUntil(702);
        checkOutput("short pulse one cycle", short_press, 1'b0);
        waitUntil(1000);
        checkOutput("t1 short count", shortCnt, 1);
        checkOutput("t1 short stamp", shortStamp, 700);
        checkOutput("t1 other pulses", longCnt + doubleCnt + repeatCnt, 0);

        // Double press: second rise seen at edge 400 together with a tick.
        applyReset(1'b0);
        applyStimulus(1'b1, 50);
        applyStimulus(1'b0, 250);
        applyStimulus(1'b1, 400);
        applyStimulus(1'b0, 600);
        waitUntil(1200);
        checkOutput("t2 double count", doubleCnt, 1);
        checkOutput("t2 double stamp", doubleStamp, 400);
        checkOutput("t2 short count", shortCnt, 0);
        checkOutput("t2 long count", longCnt, 0);

        // Long hold from reset release: long at 1000, repeat at 1300 if enabled.
        applyReset(1'b1);
        applyStimulus(1'b0, 1500);
        waitUntil(2000);
        checkOutput("t3 long count", longCnt, 1);
        checkOutput("t3 long stamp", longStamp, 1000);
        checkOutput("t3 short+double", shortCnt + doubleCnt, 0);
`ifdef PRESS_REPEAT_EN
        checkOutput("t3 repeat count", repeatCnt, 1);
        checkOutput("t3 repeat stamp", repeatStamp, 1300);
`else
        checkOutput("t3 repeat count", repeatCnt, 0);
`endif
        checkOutput("t3 multi pulse", multiCnt, 0);

        // Release on the exact LONG timeout tick: GAP wins, short 4 ms later.
        applyReset(1'b0);
        applyStimulus(1'b1, 50);
        applyStimulus(1'b0, 1000);
        waitUntil(1600);
        checkOutput("t4 long count", longCnt, 0);
        checkOutput("t4 short count", shortCnt, 1);
        checkOutput("t4 short stamp", shortStamp, 1400);

        // Reset mid-GAP with db held: no short, long 10 ms after release.
        applyReset(1'b0);
        applyStimulus(1'b1, 50);
        applyStimulus(1'b0, 100);
        waitUntil(150);
        reset_n = 1'b0;
        db = 1'b1;
        #1;
        checkOutput("t5 outputs in reset", {short_press, long_press, double_press, repeat_press}, 4'b0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        waitUntil(1050);
        checkOutput("t5 short count", shortCnt, 0);
        checkOutput("t5 long count", longCnt, 1);
        checkOutput("t5 long stamp", longStamp, 1000);
        db = 1'b0;

        // Asynchronous reset while a pulse is high clears it immediately.
        applyReset(1'b1);
        waitUntil(1001);
        checkOutput("t6 long pulse high", long_press, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("t6 long cleared async", long_press, 1'b0);
        db = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t6 quiet after release", {short_press, long_press, double_press, repeat_press}, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
